spi_frame_sequencer: RTL and testbench

Parametrised SPI-slave bit/word/frame sequencer for the PWM I/O expander's SPI front end. It runs entirely on the system clock, oversamples the SPI pins through synchronisers and supports all four SPI modes. It emits single-cycle sample/shift strobes, word-complete and frame-complete pulses, and error pulses for malformed frames, and it counts up to MAX_WORDS words per `_CS` assertion. The shift register and register-file update logic consume these strobes instead of running on raw SCLK.

---
 rtl/spi_frame_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_spi_frame_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_sequencer.sv
// SPI-slave bit/word/frame sequencer on the system clock.
// Optional SCLK inactivity abort via SPI_FRAME_TIMEOUT_EN.
//
// Ports:
//   CLK, _RST          system clock, async active-low reset
//   SCLK, _CS          raw SPI pins (synchronised here)
//   CPOL, CPHA         SPI mode, latched at frame start
//   sample_strobe      1-cycle: capture MOSI
//   shift_strobe       1-cycle: present next MISO bit
//   bit_cnt, word_cnt  bits in word / words in frame
//   word_done          1-cycle: word complete
//   frame_done         1-cycle: clean frame end
//   frame_err          1-cycle: malformed frame
//   busy               frame open
module spi_frame_sequencer #(
  parameter int WORD_BITS      = 8,
  parameter int MAX_WORDS      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic CLK,
  input  logic _RST,
  input  logic SCLK,
  input  logic _CS,
  input  logic CPOL,
  input  logic CPHA,
  output logic sample_strobe,
  output logic shift_strobe,
  output logic [$clog2(WORD_BITS)-1:0]   bit_cnt,
  output logic [$clog2(MAX_WORDS+1)-1:0] word_cnt,
  output logic word_done,
  output logic frame_done,
  output logic frame_err,
  output logic busy
);

  localparam int BW = $clog2(WORD_BITS);
  localparam int WW = $clog2(MAX_WORDS+1);
  localparam logic [BW-1:0] BLAST = BW'(WORD_BITS-1);
  localparam logic [WW-1:0] WMAX  = WW'(MAX_WORDS);

  typedef enum logic [1:0] {
    IDLE, ACTIVE, FULL, WAIT_CS
  } state_t;

  state_t state_q, state_d;

  logic sclk_s1_q, sclk_s2_q, sclk_h_q;
  logic cs_s1_q, cs_s2_q, cs_h_q;

  logic cpol_q, cpol_d;
  logic cpha_q, cpha_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [WW-1:0] word_q, word_d;
  logic ovr_q, ovr_d;
  logic smp_q, smp_d;
  logic shf_q, shf_d;
  logic wdone_q, wdone_d;
  logic fpend_q, fpend_d;
  logic epend_q, epend_d;
  logic fdone_q, ferr_q, busy_q;

  logic sclk_chg, cs_fall, cs_rise;
  logic lead_e, trail_e, smp_e, shf_e;
  logic to_hit;

  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      sclk_s1_q <= 1'b0;
      sclk_s2_q <= 1'b0;
      sclk_h_q  <= 1'b0;
      cs_s1_q   <= 1'b1;
      cs_s2_q   <= 1'b1;
      cs_h_q    <= 1'b1;
    end else begin
      sclk_s1_q <= SCLK;
      sclk_s2_q <= sclk_s1_q;
      sclk_h_q  <= sclk_s2_q;
      cs_s1_q   <= _CS;
      cs_s2_q   <= cs_s1_q;
      cs_h_q    <= cs_s2_q;
    end
  end

  assign sclk_chg = sclk_s2_q ^ sclk_h_q;
  assign cs_fall  = cs_h_q & ~cs_s2_q;
  assign cs_rise  = ~cs_h_q & cs_s2_q;

  // Leading edge moves away from the idle level.
  assign lead_e  = sclk_chg & (sclk_s2_q ^ cpol_q);
  assign trail_e = sclk_chg & ~(sclk_s2_q ^ cpol_q);
  assign smp_e   = cpha_q ? trail_e : lead_e;
  assign shf_e   = cpha_q ? lead_e : trail_e;

`ifdef SPI_FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES-1);

  logic [TW-1:0] to_q, to_d;

  always_comb begin
    to_d   = '0;
    to_hit = 1'b0;
    if ((state_q == ACTIVE || state_q == FULL) && !sclk_chg) begin
      if (to_q == TLAST) to_hit = 1'b1;
      else               to_d   = to_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) to_q <= '0;
    else       to_q <= to_d;
  end
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    bit_d   = bit_q;
    word_d  = word_q;
    ovr_d   = ovr_q;
    smp_d   = 1'b0;
    shf_d   = 1'b0;
    fpend_d = 1'b0;
    epend_d = 1'b0;
    // Counter wrapped on the strobe just issued.
    wdone_d = smp_q & (bit_q == '0);
    unique case (state_q)
      IDLE: begin
        bit_d  = '0;
        word_d = '0;
        ovr_d  = 1'b0;
        if (cs_fall) begin
          state_d = ACTIVE;
          cpol_d  = CPOL;
          cpha_d  = CPHA;
        end
      end
      ACTIVE, FULL: begin
        if (cs_rise) begin
          if (bit_q == '0 && word_q != '0 && !ovr_q)
            fpend_d = 1'b1;
          else
            epend_d = 1'b1;
          state_d = IDLE;
          bit_d   = '0;
          word_d  = '0;
          ovr_d   = 1'b0;
        end else if (to_hit) begin
          epend_d = 1'b1;
          state_d = WAIT_CS;
          bit_d   = '0;
          word_d  = '0;
          ovr_d   = 1'b0;
        end else if (state_q == FULL) begin
          if (smp_e) ovr_d = 1'b1;
        end else begin
          shf_d = shf_e;
          if (smp_e) begin
            smp_d = 1'b1;
            if (bit_q == BLAST) begin
              bit_d  = '0;
              word_d = word_q + 1'b1;
              if (word_d == WMAX) state_d = FULL;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end
      end
      WAIT_CS: begin
        if (cs_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      state_q <= IDLE;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      bit_q   <= '0;
      word_q  <= '0;
      ovr_q   <= 1'b0;
      smp_q   <= 1'b0;
      shf_q   <= 1'b0;
      wdone_q <= 1'b0;
      fpend_q <= 1'b0;
      epend_q <= 1'b0;
      fdone_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      bit_q   <= bit_d;
      word_q  <= word_d;
      ovr_q   <= ovr_d;
      smp_q   <= smp_d;
      shf_q   <= shf_d;
      wdone_q <= wdone_d;
      fpend_q <= fpend_d;
      epend_q <= epend_d;
      fdone_q <= fpend_q;
      ferr_q  <= epend_q;
      // Lags state by one so it drops with the end pulse.
      busy_q  <= (state_q != IDLE);
    end
  end

  assign sample_strobe = smp_q;
  assign shift_strobe  = shf_q;
  assign bit_cnt       = bit_q;
  assign word_cnt      = word_q;
  assign word_done     = wdone_q;
  assign frame_done    = fdone_q;
  assign frame_err     = ferr_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Directed bench for spi_frame_sequencer.
// Pulse counters on negedge; deltas checked per scenario.
module tb_spi_frame_sequencer;

  logic CLK = 1'b0;
  logic _RST = 1'b0;
  logic SCLK = 1'b0;
  logic _CS = 1'b1;
  logic CPOL = 1'b0;
  logic CPHA = 1'b0;
  logic sample_strobe, shift_strobe;
  logic [2:0] bit_cnt;
  logic [2:0] word_cnt;
  logic word_done, frame_done, frame_err, busy;

  int ncmp = 0;
  int nerr = 0;

  int t_smp = 0, t_shf = 0, t_wd = 0;
  int t_fd = 0, t_fe = 0, t_ovl = 0;
  int b_smp, b_shf, b_wd, b_fd, b_fe;
  int wd_hist [0:63];
  int lat;

  spi_frame_sequencer #(
    .WORD_BITS(8),
    .MAX_WORDS(4),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .CLK(CLK),
    ._RST(_RST),
    .SCLK(SCLK),
    ._CS(_CS),
    .CPOL(CPOL),
    .CPHA(CPHA),
    .sample_strobe(sample_strobe),
    .shift_strobe(shift_strobe),
    .bit_cnt(bit_cnt),
    .word_cnt(word_cnt),
    .word_done(word_done),
    .frame_done(frame_done),
    .frame_err(frame_err),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (sample_strobe) t_smp++;
    if (shift_strobe)  t_shf++;
    if (word_done) begin
      if (t_wd < 64) wd_hist[t_wd] = int'(word_cnt);
      t_wd++;
    end
    if (frame_done) t_fd++;
    if (frame_err)  t_fe++;
    if (int'(word_done) + int'(frame_done)
        + int'(frame_err) > 1) t_ovl++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic snap();
    b_smp = t_smp;
    b_shf = t_shf;
    b_wd  = t_wd;
    b_fd  = t_fd;
    b_fe  = t_fe;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic frame_start(input logic pol,
                             input logic pha);
    CPOL = pol;
    CPHA = pha;
    SCLK = pol;
    cyc(4);
    _CS = 1'b0;
    cyc(8);
  endtask

  task automatic sclk_cyc(input int n);
    repeat (n) begin
      SCLK = ~SCLK;
      cyc(4);
      SCLK = ~SCLK;
      cyc(4);
    end
  endtask

  // Raise _CS; report negedges until an end pulse (0: none).
  task automatic cs_up(output int l);
    l = 0;
    cyc(4);
    _CS = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge CLK);
      if (l == 0 && (frame_done || frame_err)) l = k;
    end
    cyc(4);
  endtask

  initial begin
    // Reset values
    cyc(3);
    chk("rst_smp",  sample_strobe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bit",  bit_cnt, 0);
    chk("rst_word", word_cnt, 0);
    _RST = 1'b1;
    cyc(5);
    chk("idle_busy", busy, 0);
    chk("idle_fe",   frame_err, 0);

    // Mode 0, two words, latency checks
    snap();
    frame_start(1'b0, 1'b0);
    chk("m0_busy", busy, 1);
    SCLK = 1'b1;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge CLK);
      if (lat == 0 && sample_strobe) lat = k;
    end
    chk("m0_smp_lat", lat, 3);
    SCLK = 1'b0;
    cyc(4);
    sclk_cyc(15);
    chk("m0_word", word_cnt, 2);
    chk("m0_bit",  bit_cnt, 0);
    cs_up(lat);
    chk("m0_fd_lat", lat, 4);
    chk("m0_smp", t_smp - b_smp, 16);
    chk("m0_shf", t_shf - b_shf, 16);
    chk("m0_wd",  t_wd - b_wd, 2);
    chk("m0_wc1", wd_hist[b_wd], 1);
    chk("m0_wc2", wd_hist[b_wd+1], 2);
    chk("m0_fd",  t_fd - b_fd, 1);
    chk("m0_fe",  t_fe - b_fe, 0);
    chk("m0_busy_end", busy, 0);

    // Mode 3, one word
    snap();
    frame_start(1'b1, 1'b1);
    SCLK = 1'b0;
    cyc(5);
    chk("m3_lead_shf", t_shf - b_shf, 1);
    chk("m3_lead_smp", t_smp - b_smp, 0);
    cyc(3);
    SCLK = 1'b1;
    cyc(5);
    chk("m3_trail_smp", t_smp - b_smp, 1);
    chk("m3_trail_shf", t_shf - b_shf, 1);
    cyc(3);
    sclk_cyc(7);
    cs_up(lat);
    chk("m3_smp", t_smp - b_smp, 8);
    chk("m3_wd",  t_wd - b_wd, 1);
    chk("m3_fd",  t_fd - b_fd, 1);
    chk("m3_fe",  t_fe - b_fe, 0);

    // Partial word: 5 bits
    snap();
    frame_start(1'b0, 1'b0);
    sclk_cyc(5);
    chk("pw_bit", bit_cnt, 5);
    cs_up(lat);
    chk("pw_lat", lat, 4);
    chk("pw_wd",  t_wd - b_wd, 0);
    chk("pw_fe",  t_fe - b_fe, 1);
    chk("pw_fd",  t_fd - b_fd, 0);
    chk("pw_bit_end", bit_cnt, 0);

    // Overrun: 5 words into a 4-word frame
    snap();
    frame_start(1'b0, 1'b0);
    sclk_cyc(40);
    chk("ov_word", word_cnt, 4);
    cs_up(lat);
    chk("ov_wd",  t_wd - b_wd, 4);
    chk("ov_wc4", wd_hist[b_wd+3], 4);
    chk("ov_smp", t_smp - b_smp, 32);
    chk("ov_shf", t_shf - b_shf, 31);
    chk("ov_fe",  t_fe - b_fe, 1);
    chk("ov_fd",  t_fd - b_fd, 0);

    // Reset mid-frame
    snap();
    frame_start(1'b0, 1'b0);
    sclk_cyc(3);
    chk("rm_bit", bit_cnt, 3);
    _RST = 1'b0;
    #1;
    chk("rm_busy", busy, 0);
    chk("rm_bitz", bit_cnt, 0);
    chk("rm_smp",  sample_strobe, 0);
    _CS = 1'b1;
    cyc(4);
    _RST = 1'b1;
    cyc(10);
    chk("rm_fe", t_fe - b_fe, 0);
    chk("rm_fd", t_fd - b_fd, 0);
    snap();
    frame_start(1'b0, 1'b0);
    sclk_cyc(8);
    cs_up(lat);
    chk("rm2_smp", t_smp - b_smp, 8);
    chk("rm2_wc",  wd_hist[b_wd], 1);
    chk("rm2_fd",  t_fd - b_fd, 1);
    chk("rm2_fe",  t_fe - b_fe, 0);

`ifdef SPI_FRAME_TIMEOUT_EN
    // Inactivity abort
    snap();
    frame_start(1'b0, 1'b0);
    sclk_cyc(3);
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge CLK);
      if (lat == 0 && frame_err) lat = k;
    end
    chk("to_seen", lat != 0, 1);
    chk("to_win", (lat >= 60 && lat <= 75), 1);
    chk("to_busy", busy, 1);
    chk("to_bit",  bit_cnt, 0);
    cs_up(lat);
    chk("to_fe",   t_fe - b_fe, 1);
    chk("to_busy_end", busy, 0);
`endif

    chk("excl", t_ovl, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
